// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side feeds bytes and observes writes; the loader is the slave.
interface imem_loader_if #(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
);
  logic [7:0]   inData;
  logic         inValid;
  logic         inReady;
  logic         wrEn;
  logic [D-1:0] wrAddr;
  logic [W-1:0] wrData;

  modport master (
    output inData, inValid,
    input  inReady, wrEn, wrAddr, wrData
  );

  modport slave (
    input  inData, inValid,
    output inReady, wrEn, wrAddr, wrData
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream (length, 2-byte words, XOR
// checksum), writes each 9-bit word to instruction memory and holds the core
// in reset until a verified image is in place.
module imem_loader #(
  parameter int unsigned D = 12,
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpuHold,
  output logic         loadDone,
  output logic         loadErr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD_HI,
    S_WORD_LO,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t       state;
  logic [3:0]   len_hi;
  logic [11:0]  remaining;
  logic [D-1:0] addr;
  logic [7:0]   acc;
  logic         hi_bit;

  logic         ready_q;
  logic         wr_en_q;
  logic [D-1:0] wr_addr_q;
  logic [W-1:0] wr_data_q;
  logic         accept;

  // ready_q is registered alongside the state, so this has no path from inValid to inReady
  assign accept      = bus.inValid && ready_q;
  assign bus.inReady = ready_q;
  assign bus.wrEn    = wr_en_q;
  assign bus.wrAddr  = wr_addr_q;
  assign bus.wrData  = wr_data_q;

  // Frame parser FSM; every output register is loaded on the transition into
  // the state it belongs to, so outputs track the state without decode logic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      remaining <= '0;
      addr      <= '0;
      acc       <= '0;
      hi_bit    <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cpuHold   <= 1'b1;
      loadDone  <= 1'b0;
      loadErr   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_HI;
            ready_q  <= 1'b1;
            cpuHold  <= 1'b1;
            loadDone <= 1'b0;
            loadErr  <= 1'b0;
            addr     <= '0;
            acc      <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= bus.inData[3:0];
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            if ({len_hi, bus.inData} == 12'd0) begin
              state   <= S_ERR;
              ready_q <= 1'b0;
              loadErr <= 1'b1;
              cpuHold <= 1'b1;
            end else begin
              remaining <= {len_hi, bus.inData};
              addr      <= '0;
              state     <= S_WORD_HI;
            end
          end
        end
        S_WORD_HI: begin
          if (accept) begin
            acc    <= acc ^ bus.inData;
            hi_bit <= bus.inData[0];
            if (bus.inData[7:1] != 7'd0) begin
              state   <= S_ERR;
              ready_q <= 1'b0;
              loadErr <= 1'b1;
              cpuHold <= 1'b1;
            end else begin
              state <= S_WORD_LO;
            end
          end
        end
        S_WORD_LO: begin
          // write strobe and payload are loaded here so they are valid for
          // exactly the single cycle spent in S_WRITE
          if (accept) begin
            acc       <= acc ^ bus.inData;
            state     <= S_WRITE;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr;
            wr_data_q <= W'({hi_bit, bus.inData});
          end
        end
        S_WRITE: begin
          addr      <= addr + D'(1);
          remaining <= remaining - 12'd1;
          ready_q   <= 1'b1;
          state     <= (remaining == 12'd1) ? S_CKSUM : S_WORD_HI;
        end
        S_CKSUM: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (bus.inData == acc) begin
              state    <= S_DONE;
              loadDone <= 1'b1;
              cpuHold  <= 1'b0;
            end else begin
              state   <= S_ERR;
              loadErr <= 1'b1;
              cpuHold <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized frames with
// random inValid gaps, compared against a frame-level reference model.
module tb_imem_loader;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [20:0] wr_q_t [$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpuHold, loadDone, loadErr;

  imem_loader_if #(.D(12), .W(9)) bus ();

  imem_loader #(.D(12), .W(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpuHold  (cpuHold),
    .loadDone (loadDone),
    .loadErr  (loadErr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  wr_q_t got;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Capture every write strobe and confirm no byte is accepted during it
  always @(negedge clk) begin
    if (reset && bus.wrEn === 1'b1) begin
      got.push_back({bus.wrAddr, bus.wrData});
      check_eq("ready_in_write", 32'(bus.inReady), 32'd0);
    end
  end

  // Frame-level reference: parse the byte list directly
  function automatic void ref_model(input byte_q_t f, output wr_q_t w, output bit done, output bit err);
    int unsigned n;
    logic [7:0] x;
    logic [7:0] hi, lo;
    w = {};
    done = 1'b0;
    err = 1'b0;
    x = 8'h00;
    n = int'(f[0] % 16) * 256 + int'(f[1]);
    if (n == 0) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      hi = f[2 + 2*i];
      lo = f[3 + 2*i];
      if (hi > 8'd1) begin
        err = 1'b1;
        return;
      end
      x = x ^ hi ^ lo;
      w.push_back({12'(i), hi[0], lo});
    end
    if (f[2 + 2*n] == x) done = 1'b1;
    else err = 1'b1;
  endfunction

  function automatic byte_q_t make_frame(input int unsigned n, input bit bad_ck, input int unsigned bad_word);
    byte_q_t f;
    logic [7:0] ck, hi, lo;
    logic [8:0] w;
    f = {};
    ck = 8'h00;
    f.push_back({4'($urandom), 4'(n >> 8)});
    f.push_back(8'(n));
    for (int unsigned i = 0; i < n; i++) begin
      w  = 9'($urandom);
      hi = {7'd0, w[8]};
      lo = w[7:0];
      if (i == bad_word) hi = 8'($urandom_range(2, 255));
      ck = ck ^ hi ^ lo;
      f.push_back(hi);
      f.push_back(lo);
    end
    if (bad_ck) ck = ck ^ 8'($urandom_range(1, 255));
    f.push_back(ck);
    return f;
  endfunction

  // Called at a negedge; the accept decision uses inReady as it stands for the next edge
  task automatic send(input byte_q_t f, input bit gaps, input int unsigned limit, output int unsigned sent);
    int unsigned idx;
    int unsigned cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    while (idx < limit && idx < f.size() && cyc < 2000 && loadErr !== 1'b1) begin
      acc = 1'b0;
      start = gaps && ($urandom_range(0, 7) == 0);
      if (!gaps || $urandom_range(0, 2) != 0) begin
        bus.inValid = 1'b1;
        bus.inData  = f[idx];
        acc = (bus.inReady === 1'b1);
      end else begin
        bus.inValid = 1'b0;
        bus.inData  = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    start = 1'b0;
    bus.inValid = 1'b0;
    sent = idx;
  endtask

  task automatic run_frame(input string tag, input byte_q_t f, input bit gaps);
    wr_q_t exp;
    bit ed, ee;
    int unsigned sent, k;
    ref_model(f, exp, ed, ee);
    got = {};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(f, gaps, f.size(), sent);
    k = 0;
    while (!(loadDone === 1'b1 || loadErr === 1'b1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_finish"}, 32'(k < 50), 32'd1);
    repeat (2) @(negedge clk);
    check_eq({tag, "_done"}, 32'(loadDone), 32'(ed));
    check_eq({tag, "_err"}, 32'(loadErr), 32'(ee));
    check_eq({tag, "_hold"}, 32'(cpuHold), 32'(!ed));
    check_eq({tag, "_ready_idle"}, 32'(bus.inReady), 32'd0);
    if (ed) check_eq({tag, "_consumed"}, sent, f.size());
    check_eq({tag, "_nwrites"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check_eq({tag, "_write"}, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_inReady"}, 32'(bus.inReady), 32'd0);
    check_eq({tag, "_wrEn"}, 32'(bus.wrEn), 32'd0);
    check_eq({tag, "_wrAddr"}, 32'(bus.wrAddr), 32'd0);
    check_eq({tag, "_wrData"}, 32'(bus.wrData), 32'd0);
    check_eq({tag, "_cpuHold"}, 32'(cpuHold), 32'd1);
    check_eq({tag, "_loadDone"}, 32'(loadDone), 32'd0);
    check_eq({tag, "_loadErr"}, 32'(loadErr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t base, f;
    int unsigned sent, n, mode;
    bus.inValid = 1'b0;
    bus.inData  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    base = {8'h00, 8'h02, 8'h01, 8'h7F, 8'h00, 8'h15, 8'h6B};
    run_frame("basic", base, 1'b0);
    check_eq("basic_w0", 32'(got.size() > 0 ? got[0] : 21'h0), 32'({12'd0, 9'h17F}));
    check_eq("basic_w1", 32'(got.size() > 1 ? got[1] : 21'h0), 32'({12'd1, 9'h015}));

    f = base;
    f[6] = 8'h6A;
    run_frame("badck", f, 1'b0);

    f = {8'h00, 8'h00};
    run_frame("len0", f, 1'b0);

    f = base;
    f[2] = 8'h03;
    run_frame("badhi", f, 1'b0);

    repeat (3) run_frame("gaps", base, 1'b1);

    repeat (20) begin
      n = $urandom_range(1, 8);
      mode = $urandom_range(0, 3);
      f = make_frame(n, mode == 1, (mode == 2) ? $urandom_range(0, n - 1) : n);
      run_frame("rand", f, 1'b1);
    end

    // Abort during WORD_LO of word 1, then a fresh load
    got = {};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(base, 1'b1, 5, sent);
    check_eq("abort_sent", sent, 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    check_eq("abort_nwrites", got.size(), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    run_frame("after_rst", base, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
